// File: rtl/seq_arbiter.sv
// Round-robin owner arbitration for a single shared clear/start/ready sequencer.
// Each transaction runs IDLE -> CLEAR -> RUN -> FINISH|ABORT -> IDLE, and every output is registered.
module seq_arbiter #(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [N-1:0]   req_i,
    output logic [N-1:0]   gnt_o,
    output logic [N-1:0]   done_o,
    output logic [IDW-1:0] owner_o,
    output logic           busy_o,
    output logic           seq_clr_o,
    output logic           seq_start_o,
    input  logic           seq_ready_i,
    output logic           err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_FINISH,
        S_ABORT
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [N-1:0]   done_q, done_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           clr_q, clr_d;
    logic           start_q, start_d;
    logic           err_q, err_d;

    logic [IDW-1:0] win;
    logic [IDW-1:0] owner_inc;
    logic           own_req;
    logic           tmo_hit;

    // First set request bit at or after rr_q, wrapping back to bit 0.
    always_comb begin
        int  idx;
        logic found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req_i[idx]) begin
                win   = IDW'(idx);
                found = 1'b1;
            end
        end
    end

    assign owner_inc = (owner_q == IDW'(N - 1)) ? '0 : owner_q + 1'b1;
    assign own_req   = req_i[owner_q];
    assign tmo_hit   = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Withdrawal outranks ready, and ready outranks the timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (|req_i) state_d = S_CLEAR;
            S_CLEAR:  state_d = S_RUN;
            S_RUN: begin
                if (!own_req)         state_d = S_ABORT;
                else if (seq_ready_i) state_d = S_FINISH;
                else if (tmo_hit)     state_d = S_ABORT;
            end
            S_FINISH: state_d = S_IDLE;
            S_ABORT:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // The output registers are loaded from the state being entered.
    always_comb begin
        gnt_d   = '0;
        done_d  = '0;
        owner_d = '0;
        rr_d    = rr_q;
        cnt_d   = '0;
        busy_d  = (state_d != S_IDLE);
        clr_d   = (state_d != S_RUN);
        start_d = (state_d == S_RUN);
        err_d   = (state_d == S_ABORT);
        unique case (state_d)
            S_IDLE: ;
            S_CLEAR: begin
                gnt_d   = N'(1) << win;
                owner_d = win;
            end
            S_RUN: begin
                gnt_d   = gnt_q;
                owner_d = owner_q;
                if (state_q == S_RUN)
                    cnt_d = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
            end
            S_FINISH: begin
                done_d  = N'(1) << owner_q;
                owner_d = owner_q;
                rr_d    = owner_inc;
            end
            S_ABORT: begin
                owner_d = owner_q;
                rr_d    = owner_inc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q   <= '0;
            done_q  <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            clr_q   <= 1'b1;
            start_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            clr_q   <= clr_d;
            start_q <= start_d;
            err_q   <= err_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign owner_o     = owner_q;
    assign busy_o      = busy_q;
    assign seq_clr_o   = clr_q;
    assign seq_start_o = start_q;
    assign err_o       = err_q;

endmodule
